// File: rtl/kb_pkg.sv
// kb_pkg: shared state type, matrix sizes and small helpers for the keypad scanner.
package kb_pkg;
    localparam int KB_ROWS = 4;
    localparam int KB_COLS = 4;
    localparam int KB_IDX_W = 4;
    localparam logic [KB_COLS-1:0] KB_COL_IDLE = 4'b1111;
    typedef enum logic [2:0] {IDLE, SCAN, DEBOUNCE, REPORT, RELEASE} kb_state_e;
    function automatic logic [1:0] first_low(input logic [KB_ROWS-1:0] low);
        return low[0] ? 2'd0 : low[1] ? 2'd1 : low[2] ? 2'd2 : 2'd3;
    endfunction
    function automatic logic [KB_COLS-1:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction
endpackage

// File: rtl/kb_sync_edge.sv
// kb_sync_edge: 2-flop synchronizer with a one-clk rising-edge pulse; flops reset high.
module kb_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);
    logic [2:0] sync_q;
    always_ff @(posedge clk) begin
        if (rst) sync_q <= 3'b111;
        else     sync_q <= {sync_q[1:0], d_i};
    end
    assign q_o    = sync_q[1];
    assign rise_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix scanner with debounce, acknowledge handshake and release tracking.
// Define KB_MULTIKEY_REJECT_EN to treat multiple low rows in one column as no key.
module keypad_scanner
    import kb_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_clk,
    input  logic       en,
    input  logic [3:0] keyboard_row,
    output logic [3:0] keyboard_col,
    output logic [3:0] pressed_index,
    output logic       key_valid,
    input  logic       key_received
);
    localparam logic [3:0] TICKS = 4'(DEBOUNCE_TICKS);
    kb_state_e state_q;
    logic [1:0] col_idx_q, row_idx_q;
    logic [3:0] cnt_q, rcnt_q, col_q, idx_q;
    logic [3:0] cnt_d, rcnt_d;
    logic [3:0] rows_s, low, row_rise_unused;
    logic valid_q, tick, scan_lvl_unused, row_low, hit, abort;

    kb_sync_edge u_scan (.clk(clk), .rst(rst), .d_i(scan_clk), .q_o(scan_lvl_unused), .rise_o(tick));
    for (genvar r = 0; r < KB_ROWS; r++) begin : g_row
        kb_sync_edge u_row (.clk(clk), .rst(rst), .d_i(keyboard_row[r]), .q_o(rows_s[r]), .rise_o(row_rise_unused[r]));
    end

    assign low     = ~rows_s;
    assign row_low = low[row_idx_q];
    assign cnt_d   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    assign rcnt_d  = (rcnt_q == 4'hF) ? rcnt_q : rcnt_q + 4'd1;
`ifdef KB_MULTIKEY_REJECT_EN
    assign hit   = |low && !(|(low & (low - 4'd1)));
    assign abort = |(low & ~(4'b0001 << row_idx_q));
`else
    assign hit   = |low;
    assign abort = 1'b0;
`endif

    // en low shares the reset path but keeps the last index, which is only meaningful while key_valid
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state_q   <= IDLE;
            col_idx_q <= '0;
            cnt_q     <= '0;
            rcnt_q    <= '0;
            valid_q   <= 1'b0;
            col_q     <= KB_COL_IDLE;
            if (rst) begin
                row_idx_q <= '0;
                idx_q     <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_q   <= SCAN;
                    col_idx_q <= '0;
                    col_q     <= col_drive(2'd0);
                end
                SCAN: if (tick) begin
                    if (hit) begin
                        row_idx_q <= first_low(low);
                        cnt_q     <= 4'd1;
                        if (TICKS == 4'd1) begin
                            state_q <= REPORT;
                            valid_q <= 1'b1;
                            idx_q   <= {first_low(low), col_idx_q};
                        end else begin
                            state_q <= DEBOUNCE;
                        end
                    end else begin
                        col_idx_q <= col_idx_q + 2'd1;
                        col_q     <= col_drive(col_idx_q + 2'd1);
                    end
                end
                DEBOUNCE: if (tick) begin
                    if (!row_low || abort) begin
                        state_q   <= SCAN;
                        cnt_q     <= '0;
                        col_idx_q <= col_idx_q + 2'd1;
                        col_q     <= col_drive(col_idx_q + 2'd1);
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_d >= TICKS) begin
                            state_q <= REPORT;
                            valid_q <= 1'b1;
                            idx_q   <= {row_idx_q, col_idx_q};
                        end
                    end
                end
                REPORT: if (key_received) begin
                    state_q <= RELEASE;
                    valid_q <= 1'b0;
                    rcnt_q  <= '0;
                end
                RELEASE: if (tick) begin
                    if (row_low) begin
                        rcnt_q <= '0;
                    end else if (rcnt_d >= TICKS) begin
                        state_q   <= SCAN;
                        rcnt_q    <= '0;
                        cnt_q     <= '0;
                        col_idx_q <= col_idx_q + 2'd1;
                        col_q     <= col_drive(col_idx_q + 2'd1);
                    end else begin
                        rcnt_q <= rcnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign keyboard_col  = col_q;
    assign pressed_index = idx_q;
    assign key_valid     = valid_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed and randomized checks of keypad_scanner against a key-matrix model.
module tb_keypad_scanner;
    localparam int DT = 4;
    logic clk = 1'b0, rst = 1'b1, scan_clk = 1'b0, en = 1'b0, key_received = 1'b0;
    logic [3:0] keyboard_row, keyboard_col, pressed_index;
    logic key_valid;
    logic [15:0] keys = '0;
    logic kv_prev = 1'b0;
    int checks = 0, errors = 0, reports = 0;
    logic [3:0] col_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    keypad_scanner #(.DEBOUNCE_TICKS(DT)) dut (
        .clk(clk), .rst(rst), .scan_clk(scan_clk), .en(en),
        .keyboard_row(keyboard_row), .keyboard_col(keyboard_col),
        .pressed_index(pressed_index), .key_valid(key_valid),
        .key_received(key_received)
    );

    always #5 clk = ~clk;

    // a row reads low when any pressed key on it sits in a column driven low
    always_comb
        for (int r = 0; r < 4; r++) keyboard_row[r] = ~|(keys[r*4 +: 4] & ~keyboard_col);

    always @(posedge clk) begin
        kv_prev <= key_valid;
        if (key_valid && !kv_prev) reports <= reports + 1;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk) scan_clk = 1'b1;
        repeat (4) @(negedge clk);
        scan_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_report(output int n);
        n = 0;
        while (!key_valid && n < 16) begin
            tick();
            n++;
        end
    endtask

    task automatic ack();
        @(negedge clk) key_received = 1'b1;
        @(negedge clk) key_received = 1'b0;
        check("ack_clears_valid", 16'(key_valid), 16'd0);
    endtask

    task automatic press(input int r, input int c);
        keys = '0;
        keys[r*4+c] = 1'b1;
    endtask

    task automatic settle();
        keys = '0;
        repeat (DT + 1) tick();
    endtask

    initial begin
        int n, cur, base, r, c, hold;
        en = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_valid", 16'(key_valid), 16'd0);
        check("reset_index", 16'(pressed_index), 16'h0);
        check("reset_col", 16'(keyboard_col), 16'hF);
        rst = 1'b0;
        @(negedge clk);
        check("idle_to_scan_col0", 16'(keyboard_col), 16'hE);

        press(1, 2);
        repeat (5) tick();
        check("single_before_4th", 16'(key_valid), 16'd0);
        tick();
        check("single_valid", 16'(key_valid), 16'd1);
        check("single_index", 16'(pressed_index), 16'h6);
        check("single_col_held", 16'(keyboard_col), 16'hB);

        repeat (50) @(negedge clk);
        check("hold_valid", 16'(key_valid), 16'd1);
        check("hold_index", 16'(pressed_index), 16'h6);
        tick();
        check("tick_in_report", 16'(key_valid), 16'd1);
        ack();
        repeat (10) tick();
        check("held_no_rereport", 16'(reports), 16'd1);
        check("held_valid_low", 16'(key_valid), 16'd0);
        keys = '0;
        repeat (DT) tick();
        check("release_advance", 16'(keyboard_col), 16'h7);

        cur = 3;
        for (int i = 0; i < 8; i++) begin
            tick();
            cur = (cur + 1) % 4;
            check("wrap_col", 16'(keyboard_col), 16'(col_seq[cur]));
        end
        press(3, 0);
        wait_report(n);
        check("c0r3_valid", 16'(key_valid), 16'd1);
        check("c0r3_index", 16'(pressed_index), 16'hC);
        ack();
        settle();

        for (int k = 0; k < 4; k++) if (!keyboard_col[k]) cur = k;
        base = reports;
        press(2, cur);
        repeat (2) tick();
        keys = '0;
        tick();
        check("bounce_no_report", 16'(reports), 16'(base));
        check("bounce_valid_low", 16'(key_valid), 16'd0);
        press(2, cur);
        wait_report(n);
        check("bounce2_valid", 16'(key_valid), 16'd1);
        check("bounce2_index", 16'(pressed_index), 16'(8 + cur));
        check("bounce2_full_debounce", 16'(n >= DT), 16'd1);
        repeat (3) tick();
        check("bounce2_single", 16'(reports), 16'(base + 1));
        ack();
        settle();

        press(0, 1);
        wait_report(n);
        check("endrop_valid", 16'(key_valid), 16'd1);
        @(negedge clk) en = 1'b0;
        @(negedge clk);
        check("endrop_valid_low", 16'(key_valid), 16'd0);
        check("endrop_col_idle", 16'(keyboard_col), 16'hF);
        en = 1'b1;
        wait_report(n);
        check("reenable_valid", 16'(key_valid), 16'd1);
        check("reenable_index", 16'(pressed_index), 16'h1);
        check("reenable_debounce", 16'(n >= DT), 16'd1);

        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check("rst_in_report_valid", 16'(key_valid), 16'd0);
        check("rst_in_report_index", 16'(pressed_index), 16'h0);
        check("rst_in_report_col", 16'(keyboard_col), 16'hF);
        rst = 1'b0;
        settle();

        keys = '0;
        keys[3] = 1'b1;
        keys[11] = 1'b1;
        wait_report(n);
`ifdef KB_MULTIKEY_REJECT_EN
        check("multikey_rejected", 16'(key_valid), 16'd0);
`else
        check("multikey_valid", 16'(key_valid), 16'd1);
        check("multikey_index", 16'(pressed_index), 16'h3);
`endif
        if (key_valid) ack();
        settle();

        for (int i = 0; i < 8; i++) begin
            r = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            hold = int'($urandom_range(1, 40));
            press(r, c);
            wait_report(n);
            check("rand_valid", 16'(key_valid), 16'd1);
            check("rand_index", 16'(pressed_index), 16'(r * 4 + c));
            repeat (hold) @(negedge clk);
            check("rand_hold_index", 16'(pressed_index), 16'(r * 4 + c));
            ack();
            settle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter DEBOUNCE_TICKS, default 4: number of consecutive scan ticks a row level must hold to count as a press or a release (range 1..15).
REQ-002 clk  input  1  system clock; all logic is in this domain.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 scan_clk  input  1  slow scan clock, treated as data; each of its rising edges is one scan tick.
REQ-005 en  input  1  scanner enable; low forces IDLE.
REQ-006 keyboard_row  input  4  matrix rows, active-low (pulled up), asynchronous.
REQ-007 keyboard_col  output  4  column drive, active-low one-hot; 4'b1111 when idle.
REQ-008 pressed_index  output  4  {row_idx[1:0], col_idx[1:0]} of the reported key.
REQ-009 key_valid  output  1  a debounced key is held on pressed_index.
REQ-010 key_received  input  1  consumer acknowledge for the current key.

Function
REQ-011 keyboard_row and scan_clk shall each pass through a 2-flop synchronizer; a tick is a 0->1 transition of the synchronized scan_clk, one clk wide.
REQ-012 States: IDLE, SCAN, DEBOUNCE, REPORT, RELEASE.
REQ-013 IDLE: keyboard_col=4'b1111, key_valid=0; goes to SCAN with col_idx=0 on the cycle after en is sampled high.
REQ-014 SCAN: drives column col_idx low; on each tick samples rows; any row low -> capture row_idx, set cnt=1, go DEBOUNCE; else col_idx increments, wrapping 3->0.
REQ-015 Multiple rows low in SCAN: lowest-numbered row wins, unless KB_MULTIKEY_REJECT_EN is defined.
REQ-016 DEBOUNCE: column held; each tick, captured row low -> cnt+1, captured row high -> return to SCAN and advance col_idx; cnt reaching DEBOUNCE_TICKS -> go REPORT.
REQ-017 REPORT: key_valid=1 starting the clk after the completing tick; pressed_index stays stable until key_valid falls.
REQ-018 key_received sampled high in REPORT -> key_valid=0 next clk, go RELEASE; key_received outside REPORT is ignored.
REQ-019 RELEASE: each tick, captured row high -> rcnt+1, row low -> rcnt=0; rcnt reaching DEBOUNCE_TICKS -> SCAN with col_idx advanced; a held key never reports twice.
REQ-020 en low in any state -> IDLE on the next clk, key_valid=0, keyboard_col=4'b1111, counters cleared; any pending key is discarded.
REQ-021 A tick and key_received arriving in the same cycle in REPORT: the acknowledge takes priority, and the tick is not applied to rcnt.
REQ-022 cnt and rcnt are 4 bits wide and saturate; they never wrap.

Reset
REQ-023 rst high at a clk edge -> state=IDLE, col_idx=0, cnt=rcnt=0, key_valid=0, pressed_index=4'h0, keyboard_col=4'b1111, synchronizer flops=1.
REQ-024 rst has priority over en and all other inputs, including during REPORT.

Configuration
REQ-025 Macro KB_MULTIKEY_REJECT_EN defined: in SCAN, two or more rows low in the driven column is treated as no key, and the column advances; in DEBOUNCE, any additional row going low aborts to SCAN.
REQ-026 Macro KB_MULTIKEY_REJECT_EN undefined: the priority rule in REQ-015 applies and extra rows are ignored.

Structure
REQ-027 Shared package kb_pkg holds: state enum, KB_ROWS=4, KB_COLS=4, KB_IDX_W=4, and the idle column constant 4'b1111.
REQ-028 One sub-module, kb_sync_edge: 2-flop synchronizer plus rising-edge pulse, instanced for scan_clk and for each row bit (edge output unused for rows).
REQ-029 The FSM, counters and column decode live in keypad_scanner itself.

Verification
REQ-030 Single press: en=1, DEBOUNCE_TICKS=4, row1 held low while col2 is driven for 6 ticks -> key_valid=1 with pressed_index=4'h6, asserted the clk after the 4th tick.
REQ-031 Handshake: hold key_received=0 for 50 clk -> key_valid and index stay stable; pulse key_received for 1 clk -> key_valid=0 on the next clk; the key, still held, produces no second report.
REQ-032 Bounce: row low for 2 ticks, high for 1, low for 4 -> no report from the first burst; exactly one report after the second.
REQ-033 Wrap and release: no keys pressed for 8 ticks -> keyboard_col sequence 1110,1101,1011,0111,1110...; after a release lasting 4 ticks, the next press on col0/row3 -> index 4'hC.
REQ-034 en drop: en=0 during REPORT -> key_valid=0 and keyboard_col=4'b1111 within 1 clk; re-enabling with the key still held -> a fresh debounce, then a report.
REQ-035 Multi-key: rows 0 and 2 low on col3 -> index 4'h3 without KB_MULTIKEY_REJECT_EN; no report with the macro defined.
